// File: rtl/prog_inst_memory.sv
// prog_inst_memory: run-time loadable instruction memory.
//
// Two modes. LOAD: a ready/valid stream writes words sequentially from
// address 0. RUN: registered, one-cycle-latency fetches by byte address.
// Misaligned or out-of-range fetches return FAULT_INST with fetch_fault set.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   prog_start                   request to enter load mode (ignored in LOAD)
//   prog_valid/prog_data/
//   prog_last/prog_ready         load stream handshake
//   prog_done                    one-cycle pulse when a load ends
//   load_count                   words written by the most recent load
//   busy                         high while in load mode
//   fetch_req/fetch_addr         fetch request, byte address
//   fetch_valid/fetch_inst/
//   fetch_fault                  fetch response, one cycle after the request
module prog_inst_memory #(
  parameter int unsigned          INSTR_LEN  = 32,
  parameter int unsigned          ADDR_LEN   = 32,
  parameter int unsigned          DEPTH_LOG2 = 8,
  parameter logic [INSTR_LEN-1:0] FAULT_INST = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_start,
  input  logic                  prog_valid,
  input  logic [INSTR_LEN-1:0]  prog_data,
  input  logic                  prog_last,
  output logic                  prog_ready,
  output logic                  prog_done,
  output logic [DEPTH_LOG2:0]   load_count,
  output logic                  busy,
  input  logic                  fetch_req,
  input  logic [ADDR_LEN-1:0]   fetch_addr,
  output logic                  fetch_valid,
  output logic [INSTR_LEN-1:0]  fetch_inst,
  output logic                  fetch_fault
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef enum logic {StRun, StLoad} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  done_q, done_d;
  logic                  beat;

  logic                  fetch_go;
  logic                  addr_fault;
  logic [DEPTH_LOG2-1:0] ridx;
  logic                  fvalid_q;
  logic [INSTR_LEN-1:0]  finst_q;
  logic                  ffault_q;

  logic [INSTR_LEN-1:0]  mem [Depth];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    done_d  = 1'b0;
    beat    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (prog_start) begin
          state_d = StLoad;
          wptr_d  = '0;
          count_d = '0;
        end
      end
      StLoad: begin
        if (prog_valid) begin
          beat    = 1'b1;
          wptr_d  = wptr_q + 1'b1;
          count_d = count_q + 1'b1;
          // Leave on an explicit last beat or once the top word is written.
          if (prog_last || (wptr_q == {DEPTH_LOG2{1'b1}})) begin
            state_d = StRun;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Fetches are only served in RUN; reads and writes never share a cycle.
  assign fetch_go   = fetch_req && (state_q == StRun);
  assign addr_fault = (|fetch_addr[1:0]) || ((fetch_addr >> (DEPTH_LOG2 + 2)) != '0);
  assign ridx       = fetch_addr[DEPTH_LOG2+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      wptr_q   <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      fvalid_q <= 1'b0;
      finst_q  <= FAULT_INST;
      ffault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      fvalid_q <= fetch_go;
      if (fetch_go) begin
        ffault_q <= addr_fault;
        finst_q  <= addr_fault ? FAULT_INST : mem[ridx];
      end
    end
  end

  // Storage is deliberately not reset: a reload only overwrites its prefix.
  always_ff @(posedge clk) begin
    if (beat && !rst) begin
      mem[wptr_q] <= prog_data;
    end
  end

  assign prog_ready  = (state_q == StLoad);
  assign busy        = (state_q == StLoad);
  assign prog_done   = done_q;
  assign load_count  = count_q;
  assign fetch_valid = fvalid_q;
  assign fetch_inst  = finst_q;
  assign fetch_fault = ffault_q;

endmodule

// File: tb/tb_prog_inst_memory.sv
// Self-checking bench for prog_inst_memory (default parameters).
module tb_prog_inst_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_start = 1'b0;
  logic        prog_valid = 1'b0;
  logic [31:0] prog_data = '0;
  logic        prog_last = 1'b0;
  logic        prog_ready;
  logic        prog_done;
  logic [8:0]  load_count;
  logic        busy;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        fetch_fault;

  prog_inst_memory dut (
    .clk         (clk),
    .rst         (rst),
    .prog_start  (prog_start),
    .prog_valid  (prog_valid),
    .prog_data   (prog_data),
    .prog_last   (prog_last),
    .prog_ready  (prog_ready),
    .prog_done   (prog_done),
    .load_count  (load_count),
    .busy        (busy),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  // Reference model: word array plus a flag for words ever written.
  logic [31:0] model [256];
  bit          known [256];
  int          tests = 0;
  int          fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  task automatic write_model(input int idx, input logic [31:0] d);
    model[idx] = d;
    known[idx] = 1'b1;
  endtask

  // Single fetch, response checked one cycle later.
  task automatic fetch_check(input string tag, input logic [31:0] a);
    bit f;
    f = is_fault(a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
    check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
    check({tag, "_fault"}, 32'(fetch_fault), 32'(f));
    if (f) check({tag, "_inst"}, fetch_inst, 32'h0);
    else if (known[a / 4]) check({tag, "_inst"}, fetch_inst, model[a / 4]);
  endtask

  initial begin
    logic [31:0] dir [3];
    logic [31:0] a;
    logic [31:0] last_inst;
    int          n;
    int          acc;
    int          r;
    dir[0] = 32'h2001_0001;
    dir[1] = 32'h3402_0002;
    dir[2] = 32'h0022_1820;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", 32'(prog_ready), 32'd0);
    check("rst_done", 32'(prog_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(load_count), 32'd0);
    check("rst_fvalid", 32'(fetch_valid), 32'd0);
    check("rst_finst", fetch_inst, 32'h0);
    check("rst_ffault", 32'(fetch_fault), 32'd0);
    rst = 1'b0;

    // Directed three-word load, then fetch of word 2
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    check("ld_busy", 32'(busy), 32'd1);
    check("ld_ready", 32'(prog_ready), 32'd1);
    check("ld_count0", 32'(load_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      prog_valid = 1'b1;
      prog_data  = dir[i];
      prog_last  = (i == 2);
      tick();
      write_model(i, dir[i]);
      if (i < 2) check("ld_done_early", 32'(prog_done), 32'd0);
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    check("ld_done", 32'(prog_done), 32'd1);
    check("ld_ready_off", 32'(prog_ready), 32'd0);
    check("ld_busy_off", 32'(busy), 32'd0);
    check("ld_count3", 32'(load_count), 32'd3);
    fetch_check("ld_fetch8", 32'h8);
    check("ld_done_once", 32'(prog_done), 32'd0);

    // Faulting and boundary fetches; outputs hold when idle
    fetch_check("flt_6", 32'h6);
    fetch_check("flt_400", 32'h400);
    tick();
    check("hold_valid", 32'(fetch_valid), 32'd0);
    check("hold_fault", 32'(fetch_fault), 32'd1);
    fetch_check("flt_3fc", 32'h3FC);

    // Simultaneous start + fetch, then randomized load with gaps and fetch attempts
    prog_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    tick();
    prog_start = 1'b0;
    check("sim_fvalid", 32'(fetch_valid), 32'd1);
    check("sim_finst", fetch_inst, model[0]);
    check("sim_busy", 32'(busy), 32'd1);
    n   = $urandom_range(4, 12);
    acc = 0;
    for (int c = 0; c < 200 && acc < n; c++) begin
      prog_valid = (c > 100) || ($urandom_range(0, 1) == 1);
      prog_data  = $urandom;
      prog_last  = prog_valid && (acc == n - 1);
      fetch_req  = ($urandom_range(0, 1) == 1);
      fetch_addr = 32'(4 * $urandom_range(0, 15));
      tick();
      check("rl_no_fetch", 32'(fetch_valid), 32'd0);
      if (prog_valid) begin
        write_model(acc, prog_data);
        acc++;
      end
      if (acc < n) check("rl_done_early", 32'(prog_done), 32'd0);
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    fetch_req  = 1'b0;
    check("rl_done", 32'(prog_done), 32'd1);
    check("rl_count", 32'(load_count), 32'(n));

    // Back-to-back random fetches
    last_inst = '0;
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) a = $urandom;
      else if (r == 1) a = 32'(4 * $urandom_range(0, n - 1) + $urandom_range(1, 3));
      else a = 32'(4 * $urandom_range(0, n - 1));
      fetch_req  = 1'b1;
      fetch_addr = a;
      tick();
      check("b2b_valid", 32'(fetch_valid), 32'd1);
      check("b2b_fault", 32'(fetch_fault), 32'(is_fault(a)));
      if (is_fault(a)) check("b2b_inst", fetch_inst, 32'h0);
      else if (known[a / 4]) check("b2b_inst", fetch_inst, model[a / 4]);
      last_inst = fetch_inst;
    end
    fetch_req = 1'b0;
    tick();
    check("b2b_idle_valid", 32'(fetch_valid), 32'd0);
    check("b2b_idle_hold", fetch_inst, last_inst);

    // Full-depth load auto-terminates; beat 257 is dropped
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      prog_valid = 1'b1;
      prog_data  = $urandom;
      tick();
      write_model(k - 1, prog_data);
      if (k == 255) check("full_ready255", 32'(prog_ready), 32'd1);
    end
    check("full_ready_off", 32'(prog_ready), 32'd0);
    check("full_done", 32'(prog_done), 32'd1);
    check("full_count", 32'(load_count), 32'd256);
    prog_data = ~model[0];
    tick();
    prog_valid = 1'b0;
    check("full_done_once", 32'(prog_done), 32'd0);
    check("full_count_hold", 32'(load_count), 32'd256);
    fetch_check("full_word0", 32'h0);
    fetch_check("full_word255", 32'h3FC);

    // Back-pressure, ignored prog_start/prog_last/fetch during LOAD
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      prog_valid = (i != 1);
      prog_data  = $urandom;
      prog_last  = (i >= 1);
      prog_start = (i == 1);
      tick();
      check("bp_no_fetch", 32'(fetch_valid), 32'd0);
      if (prog_valid) write_model((i == 0) ? 0 : 1, prog_data);
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    prog_start = 1'b0;
    fetch_req  = 1'b0;
    check("bp_done", 32'(prog_done), 32'd1);
    check("bp_count", 32'(load_count), 32'd2);
    fetch_check("bp_w0", 32'h0);
    fetch_check("bp_w1", 32'h4);
    fetch_check("bp_w2_kept", 32'h8);

    // Reset in the middle of a load
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prog_valid = 1'b1;
      prog_data  = $urandom;
      tick();
      write_model(i, prog_data);
    end
    prog_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_ready", 32'(prog_ready), 32'd0);
    check("mr_count", 32'(load_count), 32'd0);
    check("mr_done", 32'(prog_done), 32'd0);
    tick();
    check("mr_done_later", 32'(prog_done), 32'd0);
    fetch_check("mr_w1", 32'h4);
    fetch_check("mr_w2_kept", 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
